// File: rtl/mc_control_unit.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXECUTE/MEM/WB strobes,
// memory ready handshake with timeout, trap handling and retired-instruction count.
module mc_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 5,
  parameter int EXT_BRANCH  = 1,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic [4:0]           rt,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic [1:0]           size_in,
  output logic                 load_unsigned,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_source,
  output logic [5:0]           alu_ctrl,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic                 mem_to_reg,
  output logic                 link_to_wb,
  output logic                 lui_rt,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADDR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTYPE = 4'd6, S_ITYPE = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_TRAP = 4'd15
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_V = TIMEOUT_W'(MEM_TIMEOUT);

  state_t                 state_q, state_d;
  logic [1:0]             cause_q, cause_d;
  logic                   rtype_q, rtype_d;
  logic [TIMEOUT_W-1:0]   wait_q, wait_d;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   retire;

  logic is_load, is_store, is_itype, is_branch, is_jump, is_rtype, is_nop, tmo;
  logic [1:0] msize;
  logic [5:0] rtype_alu, itype_alu, branch_alu;

  // Instruction classification; opcode/funct/rt are held stable by the IR.
  always_comb begin
    is_load   = (opcode == 6'h20) || (opcode == 6'h21) || (opcode == 6'h23) ||
                (opcode == 6'h24) || (opcode == 6'h25);
    is_store  = (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2B);
    is_itype  = (opcode == 6'h08) || (opcode == 6'h09) || (opcode == 6'h0C) ||
                (opcode == 6'h0D) || (opcode == 6'h0E) || (opcode == 6'h0F);
    is_branch = (opcode == 6'h04) || (opcode == 6'h05) ||
                ((EXT_BRANCH != 0) &&
                 ((opcode == 6'h01) || (opcode == 6'h06) || (opcode == 6'h07)));
    is_jump   = (opcode == 6'h02) || (opcode == 6'h03) ||
                ((opcode == 6'h00) && ((funct == 6'h08) || (funct == 6'h09)));
    is_rtype  = (opcode == 6'h00) &&
                ((funct[5:3] == 3'b100) || (funct == 6'h2A) || (funct == 6'h2B));
    is_nop    = (opcode == 6'h00) && (funct == 6'h00);
    tmo       = (MEM_TIMEOUT > 0) && (wait_q == TMO_V) && !mem_ready;

    case (opcode)
      6'h20, 6'h24, 6'h28: msize = 2'b00;
      6'h21, 6'h25, 6'h29: msize = 2'b01;
      default:             msize = 2'b11;
    endcase

    case (funct)
      6'h2A:   rtype_alu = 6'b101000;
      6'h2B:   rtype_alu = 6'b101001;
      default: rtype_alu = {3'b100, funct[2:0]};
    endcase

    case (opcode)
      6'h09:   itype_alu = 6'b100001;
      6'h0C:   itype_alu = 6'b100100;
      6'h0D:   itype_alu = 6'b100101;
      6'h0E:   itype_alu = 6'b100110;
      default: itype_alu = 6'b100000;
    endcase

    case (opcode)
      6'h04:   branch_alu = 6'b111100;
      6'h05:   branch_alu = 6'b111101;
      6'h06:   branch_alu = 6'b111110;
      6'h07:   branch_alu = 6'b111111;
      default: branch_alu = (rt == 5'd0) ? 6'b111000 : 6'b111001;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    rtype_d       = rtype_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    size_in       = 2'b00;
    load_unsigned = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_ctrl      = 6'b000000;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 1'b0;
    link_to_wb    = 1'b0;
    lui_rt        = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          alu_ctrl  = 6'b100001;
          state_d   = S_DECODE;
        end else if (tmo) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = 6'b100001;
        if (is_load || is_store)  state_d = S_MEMADDR;
        else if (is_itype) begin  state_d = S_ITYPE; rtype_d = 1'b0; end
        else if (is_branch)       state_d = S_BRANCH;
        else if (is_jump)         state_d = S_JUMP;
        else if (is_rtype) begin  state_d = S_RTYPE; rtype_d = 1'b1; end
        else if (is_nop)          state_d = S_FETCH;
        else begin                state_d = S_TRAP;  cause_d = 2'b01; end
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = 6'b100000;
        state_d   = is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD, S_MEMWR: begin
        mem_req       = 1'b1;
        iord          = 1'b1;
        mem_we        = (state_q == S_MEMWR);
        size_in       = msize;
        load_unsigned = (opcode == 6'h24) || (opcode == 6'h25);
        if (mem_ready)  state_d = (state_q == S_MEMWR) ? S_FETCH : S_MEMWB;
        else if (tmo) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_MEMWB: begin
        reg_write     = 1'b1;
        mem_to_reg    = 1'b1;
        size_in       = msize;
        load_unsigned = (opcode == 6'h24) || (opcode == 6'h25);
        state_d       = S_FETCH;
      end
      S_RTYPE: begin
        alu_src_a = 1'b1;
        alu_ctrl  = rtype_alu;
        state_d   = S_ALUWB;
      end
      S_ITYPE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = itype_alu;
        lui_rt    = (opcode == 6'h0F);
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = rtype_q ? 2'b01 : 2'b00;
        lui_rt    = !rtype_q && (opcode == 6'h0F);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        alu_ctrl      = branch_alu;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        if (opcode == 6'h00) begin
          pc_source = 2'b11;
          alu_ctrl  = 6'b111011;
          if (funct == 6'h09) begin
            reg_write  = 1'b1;
            link_to_wb = 1'b1;
            reg_dst    = 2'b01;
          end
        end else begin
          pc_source = 2'b10;
          if (opcode == 6'h03) begin
            reg_write  = 1'b1;
            link_to_wb = 1'b1;
            reg_dst    = 2'b10;
          end
        end
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    retire = (state_d == S_FETCH) && (state_q != S_FETCH);

    // Any state change restarts the wait count for the next access.
    if (state_d != state_q)            wait_d = '0;
    else if (mem_req && !mem_ready)    wait_d = wait_q + 1'b1;
    else                               wait_d = wait_q;

    trap       = (state_q == S_TRAP);
    trap_cause = cause_q;
    state      = state_q;
    instret    = instret_q;

    if (rst) begin
      mem_req = 1'b0; mem_we = 1'b0; iord = 1'b0; size_in = 2'b00;
      load_unsigned = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
      pc_write_cond = 1'b0; pc_source = 2'b00; alu_ctrl = 6'b000000;
      alu_src_a = 1'b0; alu_src_b = 2'b00; reg_write = 1'b0; reg_dst = 2'b00;
      mem_to_reg = 1'b0; link_to_wb = 1'b0; lui_rt = 1'b0; trap = 1'b0;
      trap_cause = 2'b00; state = 4'd0; instret = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cause_q   <= 2'b00;
      rtype_q   <= 1'b0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      rtype_q <= rtype_d;
      wait_q  <= wait_d;
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized scoreboard bench for mc_control_unit: a per-instruction model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_mc_control_unit;
  localparam int MEM_TIMEOUT = 16;

  localparam int C_LOAD = 0, C_STORE = 1, C_ITYPE = 2, C_BRANCH = 3,
                 C_JUMP = 4, C_RTYPE = 5, C_NOP = 6, C_ILL = 7;
  localparam logic [3:0] FETCH = 0, DECODE = 1, MEMADDR = 2, MEMRD = 3, MEMWB = 4,
                         MEMWR = 5, RTYPE = 6, ITYPE = 7, ALUWB = 8, BRANCH = 9,
                         JUMP = 10, TRAP = 15;

  typedef struct packed {
    logic mem_req, mem_we, iord;
    logic [1:0] size_in;
    logic load_unsigned, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic [5:0] alu_ctrl;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic reg_write;
    logic [1:0] reg_dst;
    logic mem_to_reg, link_to_wb, lui_rt, trap;
    logic [1:0] trap_cause;
    logic [3:0] state;
    logic [31:0] instret;
  } outv_t;

  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rt = '0;
  outv_t act;

  mc_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .TIMEOUT_W(5), .EXT_BRANCH(1),
                    .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rt(rt),
    .mem_ready(mem_ready), .mem_req(act.mem_req), .mem_we(act.mem_we),
    .iord(act.iord), .size_in(act.size_in), .load_unsigned(act.load_unsigned),
    .ir_write(act.ir_write), .pc_write(act.pc_write),
    .pc_write_cond(act.pc_write_cond), .pc_source(act.pc_source),
    .alu_ctrl(act.alu_ctrl), .alu_src_a(act.alu_src_a), .alu_src_b(act.alu_src_b),
    .reg_write(act.reg_write), .reg_dst(act.reg_dst), .mem_to_reg(act.mem_to_reg),
    .link_to_wb(act.link_to_wb), .lui_rt(act.lui_rt), .trap(act.trap),
    .trap_cause(act.trap_cause), .state(act.state), .instret(act.instret)
  );

  always #5 clk = ~clk;

  outv_t exp_q[$];
  int compared = 0, mismatched = 0;
  logic [31:0] m_instret = 0;
  logic [1:0]  m_cause = 0;
  bit          m_rflag = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outv_t e;
      e = exp_q.pop_front();
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL cycle_out #%0d (exp state %0d, op %h fn %h): act=%h exp=%h",
                 compared, e.state, opcode, funct, act, e);
      end
    end
  end

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return C_LOAD;
      6'h28, 6'h29, 6'h2B:               return C_STORE;
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return C_ITYPE;
      6'h04, 6'h05, 6'h01, 6'h06, 6'h07: return C_BRANCH;
      6'h02, 6'h03:                      return C_JUMP;
      6'h00: begin
        if (fn == 6'h08 || fn == 6'h09) return C_JUMP;
        if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B) return C_RTYPE;
        if (fn == 6'h00) return C_NOP;
        return C_ILL;
      end
      default: return C_ILL;
    endcase
  endfunction

  function automatic outv_t model_out(input logic [3:0] st, input logic rdy);
    outv_t o;
    logic [1:0] sz;
    o = '0;
    o.state = st; o.instret = m_instret; o.trap_cause = m_cause;
    sz = (opcode == 6'h20 || opcode == 6'h24 || opcode == 6'h28) ? 2'b00 :
         (opcode == 6'h21 || opcode == 6'h25 || opcode == 6'h29) ? 2'b01 : 2'b11;
    case (st)
      FETCH: begin
        o.mem_req = 1;
        if (rdy) begin o.ir_write = 1; o.pc_write = 1; o.alu_src_b = 2'b01; o.alu_ctrl = 6'h21; end
      end
      DECODE:  begin o.alu_src_b = 2'b11; o.alu_ctrl = 6'h21; end
      MEMADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 6'h20; end
      MEMRD, MEMWR, MEMWB: begin
        o.size_in = sz;
        o.load_unsigned = (opcode == 6'h24 || opcode == 6'h25);
        if (st == MEMWB) begin o.reg_write = 1; o.mem_to_reg = 1; end
        else begin o.mem_req = 1; o.iord = 1; o.mem_we = (st == MEMWR); end
      end
      RTYPE: begin
        o.alu_src_a = 1;
        case (funct)
          6'h2A: o.alu_ctrl = 6'b101000;
          6'h2B: o.alu_ctrl = 6'b101001;
          default: o.alu_ctrl = 6'h20 + (funct - 6'h20);
        endcase
      end
      ITYPE: begin
        o.alu_src_a = 1; o.alu_src_b = 2'b10;
        case (opcode)
          6'h09: o.alu_ctrl = 6'b100001;
          6'h0C: o.alu_ctrl = 6'b100100;
          6'h0D: o.alu_ctrl = 6'b100101;
          6'h0E: o.alu_ctrl = 6'b100110;
          default: o.alu_ctrl = 6'b100000;
        endcase
        o.lui_rt = (opcode == 6'h0F);
      end
      ALUWB: begin
        o.reg_write = 1;
        o.reg_dst = m_rflag ? 2'b01 : 2'b00;
        o.lui_rt = !m_rflag && (opcode == 6'h0F);
      end
      BRANCH: begin
        o.alu_src_a = 1; o.pc_write_cond = 1; o.pc_source = 2'b01;
        case (opcode)
          6'h04: o.alu_ctrl = 6'b111100;
          6'h05: o.alu_ctrl = 6'b111101;
          6'h06: o.alu_ctrl = 6'b111110;
          6'h07: o.alu_ctrl = 6'b111111;
          default: o.alu_ctrl = (rt == 0) ? 6'b111000 : 6'b111001;
        endcase
      end
      JUMP: begin
        o.pc_write = 1;
        if (opcode == 6'h00) begin
          o.pc_source = 2'b11; o.alu_ctrl = 6'b111011;
          if (funct == 6'h09) begin o.reg_write = 1; o.link_to_wb = 1; o.reg_dst = 2'b01; end
        end else begin
          o.pc_source = 2'b10;
          if (opcode == 6'h03) begin o.reg_write = 1; o.link_to_wb = 1; o.reg_dst = 2'b10; end
        end
      end
      TRAP: o.trap = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic cyc(input logic [3:0] st, input logic rdy);
    mem_ready = rdy;
    exp_q.push_back(model_out(st, rdy));
    @(posedge clk); #1;
  endtask

  task automatic cycr(input logic [3:0] st);
    cyc(st, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      mem_ready = 1'($urandom_range(0, 1));
      exp_q.push_back('0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    m_instret = 0; m_cause = 0; m_rflag = 0;
  endtask

  // Access with d not-ready cycles before ready; the access times out when
  // a not-ready cycle occurs with MEM_TIMEOUT wait cycles already counted.
  task automatic access(input logic [3:0] st, input int d, output bit to);
    to = 0;
    for (int i = 0; i <= MEM_TIMEOUT; i++) begin
      cyc(st, (i >= d));
      if (i >= d) return;
      if (i == MEM_TIMEOUT) to = 1;
    end
  endtask

  task automatic trap_hold();
    repeat (3) cycr(TRAP);
    do_reset();
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rtv, input int df, input int dm);
    bit to;
    int c;
    opcode = op; funct = fn; rt = rtv;
    access(FETCH, df, to);
    if (to) begin m_cause = 2'b10; trap_hold(); return; end
    cycr(DECODE);
    c = classify(op, fn);
    case (c)
      C_NOP: m_instret++;
      C_ILL: begin m_cause = 2'b01; trap_hold(); end
      C_LOAD, C_STORE: begin
        cycr(MEMADDR);
        access((c == C_LOAD) ? MEMRD : MEMWR, dm, to);
        if (to) begin m_cause = 2'b10; trap_hold(); end
        else begin
          if (c == C_LOAD) cycr(MEMWB);
          m_instret++;
        end
      end
      C_RTYPE: begin m_rflag = 1; cycr(RTYPE); cycr(ALUWB); m_instret++; end
      C_ITYPE: begin m_rflag = 0; cycr(ITYPE); cycr(ALUWB); m_instret++; end
      C_BRANCH: begin cycr(BRANCH); m_instret++; end
      default:  begin cycr(JUMP); m_instret++; end
    endcase
  endtask

  function automatic int rnd_delay();
    int r;
    r = $urandom_range(0, 49);
    if (r == 0) return 17 + $urandom_range(0, 5);
    if (r == 1) return MEM_TIMEOUT;
    if (r < 30) return 0;
    return $urandom_range(1, 4);
  endfunction

  logic [5:0] ops [0:23] = '{6'h00, 6'h00, 6'h00, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                             6'h28, 6'h29, 6'h2B, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
                             6'h0F, 6'h04, 6'h05, 6'h01, 6'h06, 6'h07, 6'h02, 6'h03};
  logic [5:0] fns [0:15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h08, 6'h09, 6'h00, 6'h00, 6'h03, 6'h1F};

  initial begin
    @(posedge clk); #1;
    do_reset();
    // Directed: add, lw, lbu with slow memory, ready on the timeout boundary.
    run_instr(6'h00, 6'h20, 5'd0, 0, 0);
    run_instr(6'h23, 6'h00, 5'd0, 0, 0);
    run_instr(6'h24, 6'h00, 5'd0, 0, 3);
    run_instr(6'h23, 6'h00, 5'd0, 0, MEM_TIMEOUT);
    run_instr(6'h2B, 6'h00, 5'd0, 2, 1);
    // Fetch that never completes, then illegal opcode.
    run_instr(6'h00, 6'h20, 5'd0, 1000, 0);
    run_instr(6'h3F, 6'h00, 5'd0, 0, 0);
    // bgez/bltz, lui, jal, jr, jalr.
    run_instr(6'h01, 6'h00, 5'd1, 0, 0);
    run_instr(6'h01, 6'h00, 5'd0, 0, 0);
    run_instr(6'h0F, 6'h00, 5'd3, 0, 0);
    run_instr(6'h03, 6'h00, 5'd0, 0, 0);
    run_instr(6'h00, 6'h08, 5'd0, 0, 0);
    run_instr(6'h00, 6'h09, 5'd0, 1, 0);
    // Reset while a jal would be in JUMP.
    opcode = 6'h03; funct = 6'h00;
    cyc(FETCH, 1'b1);
    cycr(DECODE);
    do_reset();
    run_instr(6'h00, 6'h00, 5'd0, 0, 0);
    // Random instruction stream.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 29) == 0) ? 6'(6'h30 + $urandom_range(0, 15))
                                        : ops[$urandom_range(0, 23)];
      fn = fns[$urandom_range(0, 15)];
      run_instr(op, fn, 5'($urandom_range(0, 2)), rnd_delay(), rnd_delay());
    end
    @(negedge clk); #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: %0d left, 0 required", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
